// File: rtl/core_ctrl_if.sv
// Decode-stage sequencing bundle between decode/execute/bus and core_ctrl.
// slave: the controller side; master: the side driving decode/execute state.
interface core_ctrl_if;
  logic        id_valid_in;
  logic [4:0]  id_rs1_in;
  logic [4:0]  id_rs2_in;
  logic        id_rs1_used_in;
  logic        id_rs2_used_in;
  logic        id_reg_we_in;
  logic [4:0]  id_rd_in;
  logic        id_is_load_in;
  logic        ex_jump_en_in;
  logic [31:0] ex_jump_addr_in;
  logic        ext_hold_req_in;

  logic        hold_if_out;
  logic        bubble_ex_out;
  logic        flush_out;
  logic        jump_en_out;
  logic [31:0] jump_addr_out;
  logic        issue_out;
  logic [1:0]  state_out;

  modport slave (
    input  id_valid_in, id_rs1_in, id_rs2_in, id_rs1_used_in, id_rs2_used_in,
    input  id_reg_we_in, id_rd_in, id_is_load_in,
    input  ex_jump_en_in, ex_jump_addr_in, ext_hold_req_in,
    output hold_if_out, bubble_ex_out, flush_out, jump_en_out, jump_addr_out,
    output issue_out, state_out
  );

  modport master (
    output id_valid_in, id_rs1_in, id_rs2_in, id_rs1_used_in, id_rs2_used_in,
    output id_reg_we_in, id_rd_in, id_is_load_in,
    output ex_jump_en_in, ex_jump_addr_in, ext_hold_req_in,
    input  hold_if_out, bubble_ex_out, flush_out, jump_en_out, jump_addr_out,
    input  issue_out, state_out
  );
endinterface

// File: rtl/core_ctrl.sv
// Decode-stage pipeline sequencing controller: writeback scoreboard, RAW hazard
// detection and stall/flush arbitration (jump > flush > ext hold > hazard).
// Optional feature macro: CORE_CTRL_FWD_EN (execute forwarding; only a load in
// the youngest slot blocks). Outputs are Mealy and forced to 0 while rst is low.
module core_ctrl #(
  parameter int unsigned WB_LATENCY   = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  core_ctrl_if.slave bus
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } sb_entry_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_hold;
  logic                w_bubble;
  logic                w_flush;
  logic                w_jump_en;
  logic [ADDR_W-1:0]   w_jump_addr;
  logic                w_issue;
  logic                w_push;
  logic                w_hazard;
  sb_entry_t           w_new;
  logic [WB_LATENCY-1:0] w_slot_hit;

  assign w_new  = '{valid: 1'b1, rd: bus.id_rd_in, load: bus.id_is_load_in};
  assign w_push = w_issue & bus.id_reg_we_in & (bus.id_rd_in != '0);

  // Scoreboard shift register; slot 0 is the youngest, the last slot falls off.
  for (genvar g = 0; g < int'(WB_LATENCY); g++) begin : g_slot
    sb_entry_t r_entry;
    logic      w_block;

    if (g == 0) begin : g_head
      // Youngest slot: capture a real register write issued this cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_entry <= '0;
        else      r_entry <= w_push ? w_new : '0;
      end
    end else begin : g_tail
      // Older slots: age by one every cycle regardless of state.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_entry <= '0;
        else      r_entry <= g_slot[g-1].r_entry;
      end
    end

`ifdef CORE_CTRL_FWD_EN
    assign w_block = (g == 0) && r_entry.valid && r_entry.load;
`else
    logic w_unused_load;
    assign w_block       = r_entry.valid;
    assign w_unused_load = r_entry.load;
`endif

    assign w_slot_hit[g] = w_block &&
      ((bus.id_rs1_used_in && (bus.id_rs1_in != '0) && (bus.id_rs1_in == r_entry.rd)) ||
       (bus.id_rs2_used_in && (bus.id_rs2_in != '0) && (bus.id_rs2_in == r_entry.rd)));
  end

  assign w_hazard = bus.id_valid_in & (|w_slot_hit);

  // Priority arbitration of stall sources and next-state selection.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_jump_en   = 1'b0;
    w_jump_addr = '0;
    w_issue     = 1'b0;
    if (bus.ex_jump_en_in) begin
      w_jump_en   = 1'b1;
      w_jump_addr = bus.ex_jump_addr_in;
      w_flush     = 1'b1;
      w_bubble    = 1'b1;
      w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (r_state == ST_FLUSH) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
      if (r_cnt <= CNT_W'(1)) begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_RUN;
      end else begin
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_state_nxt = ST_FLUSH;
      end
    end else if (bus.ext_hold_req_in) begin
      w_hold      = 1'b1;
      w_bubble    = 1'b1;
      w_state_nxt = ST_HOLD;
    end else if (w_hazard) begin
      w_hold      = 1'b1;
      w_bubble    = 1'b1;
      w_state_nxt = ST_STALL;
    end else begin
      w_issue     = bus.id_valid_in;
      w_state_nxt = ST_RUN;
    end
  end

  // FSM state and flush countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Mealy outputs, held at zero while reset is asserted.
  assign bus.hold_if_out   = rst & w_hold;
  assign bus.bubble_ex_out = rst & w_bubble;
  assign bus.flush_out     = rst & w_flush;
  assign bus.jump_en_out   = rst & w_jump_en;
  assign bus.jump_addr_out = rst ? w_jump_addr : '0;
  assign bus.issue_out     = rst & w_issue;
  assign bus.state_out     = r_state;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: directed decode/jump/hold scenarios, an issue-history
// model checked every cycle, and literal expectations at key points.
module tb_core_ctrl;

  localparam int unsigned WB_LAT = 2;
  localparam int unsigned FL_CYC = 2;
`ifdef CORE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  core_ctrl_if bus();

  core_ctrl #(.WB_LATENCY(WB_LAT), .FLUSH_CYCLES(FL_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [38:0] outs();
    return {bus.hold_if_out, bus.bubble_ex_out, bus.flush_out, bus.jump_en_out,
            bus.jump_addr_out, bus.issue_out, bus.state_out};
  endfunction

  function automatic logic [38:0] pk(input bit h, input bit b, input bit f, input bit j,
                                     input logic [31:0] a, input bit i, input logic [1:0] s);
    return {h, b, f, j, a, i, s};
  endfunction

  // ---------------- model: issue history by cycle number ----------------
  typedef struct {
    int         t;
    logic [4:0] rd;
    bit         ld;
  } wr_t;

  wr_t        hist[$];
  int         mcyc       = 0;
  int         flush_left = 0;
  logic [1:0] m_state    = 2'd0;

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) &&
           ((bus.id_rs1_used_in && bus.id_rs1_in == r) ||
            (bus.id_rs2_used_in && bus.id_rs2_in == r));
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin : model
    logic [38:0] e;
    bit          haz;
    bit          blk;
    bit          iss;
    int          age;
    logic [1:0]  nxt;
    e = '0;
    if (!rst) begin
      hist.delete();
      flush_left = 0;
      m_state    = 2'd0;
    end else begin
      while (hist.size() > 0 && (mcyc - hist[0].t) > int'(WB_LAT)) void'(hist.pop_front());
      haz = 1'b0;
      foreach (hist[k]) begin
        age = mcyc - hist[k].t;
`ifdef CORE_CTRL_FWD_EN
        blk = (age == 1) && hist[k].ld;
`else
        blk = (age >= 1) && (age <= int'(WB_LAT));
`endif
        if (blk && bus.id_valid_in && reads(hist[k].rd)) haz = 1'b1;
      end
      iss = 1'b0;
      if (bus.ex_jump_en_in) begin
        e          = pk(0, 1, 1, 1, bus.ex_jump_addr_in, 0, m_state);
        flush_left = int'(FL_CYC) - 1;
        nxt        = (flush_left > 0) ? 2'd2 : 2'd0;
      end else if (flush_left > 0) begin
        e = pk(0, 1, 1, 0, 32'h0, 0, m_state);
        flush_left--;
        nxt = (flush_left > 0) ? 2'd2 : 2'd0;
      end else if (bus.ext_hold_req_in) begin
        e   = pk(1, 1, 0, 0, 32'h0, 0, m_state);
        nxt = 2'd3;
      end else if (haz) begin
        e   = pk(1, 1, 0, 0, 32'h0, 0, m_state);
        nxt = 2'd1;
      end else begin
        iss = bus.id_valid_in;
        e   = pk(0, 0, 0, 0, 32'h0, iss, m_state);
        nxt = 2'd0;
      end
      if (iss && bus.id_reg_we_in && bus.id_rd_in != 5'd0)
        hist.push_back('{t: mcyc, rd: bus.id_rd_in, ld: bus.id_is_load_in});
      m_state = nxt;
    end
    mcyc++;
    check("cycle", 64'(outs()), 64'(e));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.id_valid_in     = 1'b0;
    bus.id_rs1_in       = 5'd0;
    bus.id_rs2_in       = 5'd0;
    bus.id_rs1_used_in  = 1'b0;
    bus.id_rs2_used_in  = 1'b0;
    bus.id_reg_we_in    = 1'b0;
    bus.id_rd_in        = 5'd0;
    bus.id_is_load_in   = 1'b0;
    bus.ex_jump_en_in   = 1'b0;
    bus.ex_jump_addr_in = 32'h0;
    bus.ext_hold_req_in = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                       input bit we, input logic [4:0] rd, input bit ld);
    idle();
    bus.id_valid_in    = 1'b1;
    bus.id_rs1_in      = rs1;
    bus.id_rs1_used_in = u1;
    bus.id_rs2_in      = rs2;
    bus.id_rs2_used_in = u2;
    bus.id_reg_we_in   = we;
    bus.id_rd_in       = rd;
    bus.id_is_load_in  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current instruction until it issues; compare the stall count.
  task automatic run_until_issue(input string name, input int exp_stalls);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.issue_out) begin
        got = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
    check(name, 64'(stalls), 64'(exp_stalls));
    if (got) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with live jump/valid inputs: everything stays quiet.
    idle();
    bus.id_valid_in     = 1'b1;
    bus.ex_jump_en_in   = 1'b1;
    bus.ex_jump_addr_in = 32'h100;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'(0));
    tick();
    rst = 1'b1;
    instr(5'd1, 1, 5'd0, 0, 1, 5'd2, 0);
    @(negedge clk);
    check("first_issue", 64'(bus.issue_out), 64'(1));
    tick();

    // RAW on an ALU result.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd5, 0);
    run_until_issue("addi_x5", 0);
    instr(5'd5, 1, 5'd0, 0, 0, 5'd0, 0);
    run_until_issue("raw_x5", FWD ? 0 : 2);

    // Load-use and ALU-use on x7.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd7, 1);
    run_until_issue("load_x7", 0);
    instr(5'd7, 1, 5'd3, 1, 1, 5'd8, 0);
    run_until_issue("load_use_x7", FWD ? 1 : 2);
    instr(5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
    run_until_issue("addi_x7", 0);
    instr(5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
    run_until_issue("alu_use_x7", FWD ? 0 : 2);

    // Redirect and two-cycle flush.
    idle();
    bus.ex_jump_en_in   = 1'b1;
    bus.ex_jump_addr_in = 32'h0000_0100;
    @(negedge clk);
    check("jump_strobe", 64'(outs()), 64'(pk(0, 1, 1, 1, 32'h100, 0, 2'd0)));
    tick();
    idle();
    @(negedge clk);
    check("flush_second", 64'(outs()), 64'(pk(0, 1, 1, 0, 32'h0, 0, 2'd2)));
    tick();
    @(negedge clk);
    check("flush_done", 64'(outs()), 64'(pk(0, 0, 0, 0, 32'h0, 0, 2'd0)));
    tick();

    // External hold over a hazard for three cycles.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd9, 1);
    run_until_issue("load_x9", 0);
    instr(5'd9, 1, 5'd0, 0, 0, 5'd0, 0);
    bus.ext_hold_req_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_if_during_hold", 64'({bus.hold_if_out, bus.issue_out}), 64'(2'b10));
      if (c > 0) check("hold_state", 64'(bus.state_out), 64'(3));
      tick();
    end
    bus.ext_hold_req_in = 1'b0;
    run_until_issue("after_hold_x9", 0);

    // One-cycle hold: the hazard must still be seen once the hold drops.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd10, 1);
    run_until_issue("load_x10", 0);
    instr(5'd0, 0, 5'd10, 1, 0, 5'd0, 0);
    bus.ext_hold_req_in = 1'b1;
    @(negedge clk);
    check("hold_over_hazard", 64'(outs()), 64'(pk(1, 1, 0, 0, 32'h0, 0, 2'd0)));
    tick();
    bus.ext_hold_req_in = 1'b0;
    run_until_issue("hazard_after_hold", FWD ? 0 : 1);

    // Jump during a stall wins and flushes.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd11, 1);
    run_until_issue("load_x11", 0);
    instr(5'd11, 1, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    check("stall_x11", 64'(outs()), 64'(pk(1, 1, 0, 0, 32'h0, 0, 2'd0)));
    tick();
    bus.ex_jump_en_in   = 1'b1;
    bus.ex_jump_addr_in = 32'h0000_0200;
    @(negedge clk);
    check("jump_in_stall", 64'(outs()), 64'(pk(0, 1, 1, 1, 32'h200, 0, 2'd1)));
    tick();
    idle();
    @(negedge clk);
    check("flush_after_stall_jump", 64'(outs()), 64'(pk(0, 1, 1, 0, 32'h0, 0, 2'd2)));
    tick();
    @(negedge clk);
    check("run_after_flush", 64'(outs()), 64'(pk(0, 0, 0, 0, 32'h0, 0, 2'd0)));
    tick();

    // Writes to x0 never create a dependency.
    instr(5'd0, 0, 5'd0, 0, 1, 5'd0, 0);
    run_until_issue("x0_writer", 0);
    instr(5'd0, 1, 5'd0, 1, 0, 5'd0, 0);
    run_until_issue("x0_reader", 0);

    // Reset asserted mid-flush returns to RUN at once.
    idle();
    bus.ex_jump_en_in   = 1'b1;
    bus.ex_jump_addr_in = 32'h0000_0300;
    tick();
    idle();
    @(negedge clk);
    check("flush_before_reset", 64'(bus.state_out), 64'(2));
    #1;
    rst = 1'b0;
    #1;
    check("reset_mid_flush", 64'(outs()), 64'(0));
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("run_after_reset", 64'(outs()), 64'(0));
    tick();

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
